// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit, each held
// CLKS_PER_BIT clocks. Every output comes straight from a flop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_byte_rdy,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic [1:0] o_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             serial_d, active_d, done_d;
  logic             cnt_last;
  logic [2:0]       idx_inc;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign idx_inc  = idx_q + 3'd1;
  assign o_state  = state_q;

  // Request handshake: i_tx_byte_rdy is a level sampled on every rising edge, but
  // only acted on in IDLE; that edge also captures i_tx_byte. A request held high
  // across a frame is therefore taken again in the done cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_tx_byte_rdy) begin
          data_d   = i_tx_byte;
          state_d  = S_START;
          cnt_d    = '0;
          idx_d    = 3'd0;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end
      S_START: begin
        active_d = 1'b1;
        serial_d = 1'b0;
        if (cnt_last) begin
          cnt_d    = '0;
          idx_d    = 3'd0;
          state_d  = S_DATA;
          serial_d = data_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        active_d = 1'b1;
        serial_d = data_q[idx_q];
        if (cnt_last) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d  = S_STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx_inc;
            serial_d = data_q[idx_inc];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        active_d = 1'b1;
        serial_d = 1'b1;
        if (cnt_last) begin
          // Last stop-bit clock: next cycle is the idle-high done cycle.
          cnt_d    = '0;
          state_d  = S_IDLE;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      data_q      <= 8'd0;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      o_tx_serial <= serial_d;
      o_tx_active <= active_d;
      o_tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; frames are given as hand-written
// 10-bit line patterns, first-sent bit in the MSB.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic [7:0] tx_byte;
  logic       serial;
  logic       active;
  logic       done;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tx_byte_rdy (rdy),
    .i_tx_byte     (tx_byte),
    .o_tx_serial   (serial),
    .o_tx_active   (active),
    .o_tx_done     (done),
    .o_state       (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_serial"}, 32'(serial), 32'd1);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
  endtask

  // Called at the negedge of frame cycle 1. Checks every line cycle; returns at the
  // negedge of the done cycle, or after abort_at cycles if abort_at is nonzero.
  // inject_at pulses a request carrying inject_byte during that frame cycle.
  task automatic run_frame(input logic [9:0] pat, input string tag,
                           input int inject_at, input logic [7:0] inject_byte,
                           input int abort_at);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (abort_at != 0 && i == abort_at) return;
      if (inject_at != 0 && i == inject_at - 1) begin
        rdy     = 1'b1;
        tx_byte = inject_byte;
      end else if (inject_at != 0 && i == inject_at) begin
        rdy = 1'b0;
      end
      check($sformatf("%s_line_c%0d", tag, i + 1), 32'(serial), 32'(pat[9 - i / CPB]));
      check($sformatf("%s_active_c%0d", tag, i + 1), 32'(active), 32'd1);
      check($sformatf("%s_done_c%0d", tag, i + 1), 32'(done), 32'd0);
      step();
    end
    check({tag, "_done_pulse"},  32'(done),   32'd1);
    check({tag, "_done_active"}, 32'(active), 32'd0);
    check({tag, "_done_line"},   32'(serial), 32'd1);
    check({tag, "_done_state"},  32'(state),  32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    rdy     = 1'b0;
    tx_byte = 8'h00;
    step();
    step();
    check_idle("reset");
    check("reset_state", 32'(state), 32'd0);
    rst = 1'b0;
    step();
    step();
    check_idle("idle");

    // Single byte 0xA5
    rdy = 1'b1; tx_byte = 8'hA5;
    step();
    rdy = 1'b0; tx_byte = 8'h00;
    check("a5_state_start", 32'(state), 32'd1);
    run_frame(10'b0101001011, "a5", 0, 8'h00, 0);
    step();
    check_idle("a5_after");

    // Back-to-back 0x00 then 0xFF requested in the done cycle
    rdy = 1'b1; tx_byte = 8'h00;
    step();
    rdy = 1'b0;
    run_frame(10'b0000000001, "b2b0", 0, 8'h00, 0);
    rdy = 1'b1; tx_byte = 8'hFF;
    step();
    rdy = 1'b0;
    run_frame(10'b0111111111, "b2b1", 0, 8'h00, 0);
    step();
    check_idle("b2b_after");

    // Busy ignore: 0x3C requested at frame cycle 10 of a 0x55 frame
    rdy = 1'b1; tx_byte = 8'h55;
    step();
    rdy = 1'b0;
    run_frame(10'b0101010101, "busy", 10, 8'h3C, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle($sformatf("busy_after%0d", i));
    end

    // Reset during data bit 3 (frame cycles 17..20)
    rdy = 1'b1; tx_byte = 8'hA5;
    step();
    rdy = 1'b0;
    run_frame(10'b0101001011, "abort", 0, 8'h00, 18);
    rst = 1'b1;
    step();
    check_idle("abort_reset");
    check("abort_state", 32'(state), 32'd0);
    rst = 1'b0; rdy = 1'b1; tx_byte = 8'h81;
    step();
    rdy = 1'b0;
    run_frame(10'b0100000011, "x81", 0, 8'h00, 0);
    step();
    check_idle("x81_after");

    // Held request; byte changes after acceptance
    rdy = 1'b1; tx_byte = 8'h01;
    step();
    tx_byte = 8'h02;
    run_frame(10'b0100000001, "held0", 0, 8'h00, 0);
    step();
    rdy = 1'b0;
    run_frame(10'b0010000001, "held1", 0, 8'h00, 0);
    step();
    check_idle("held_after");
    step();
    check_idle("held_after2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 868, number of i_clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port: i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: i_tx_byte_rdy  input  1  request to send i_tx_byte; sampled every cycle.
REQ-005 SHALL have port: i_tx_byte  input  8  byte to transmit; valid when i_tx_byte_rdy=1.
REQ-006 SHALL have port: o_tx_serial  output  1  UART line; idle high.
REQ-007 SHALL have port: o_tx_active  output  1  high while a frame is on the line.
REQ-008 SHALL have port: o_tx_done  output  1  single-cycle pulse at frame completion; feeds loopback i_tx_done.
REQ-009 SHALL register all outputs; no combinational path from any input to any output.

Function
REQ-010 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-011 SHALL hold each bit on o_tx_serial for exactly CLKS_PER_BIT cycles; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 IDLE: o_tx_serial=1, o_tx_active=0; on i_tx_byte_rdy=1, latch i_tx_byte into shift register, go to START.
REQ-014 Latency: first cycle of start bit (o_tx_serial=0, o_tx_active=1) SHALL appear the cycle after i_tx_byte_rdy is sampled high in IDLE.
REQ-015 START: drive 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-016 DATA: drive latched bit[index] for CLKS_PER_BIT cycles; index 0..7 (3-bit counter); after bit 7 go to STOP.
REQ-017 STOP: drive 1 for CLKS_PER_BIT cycles; on the final cycle transition to IDLE.
REQ-018 o_tx_done SHALL be 1 for exactly one cycle, the first cycle after the stop bit ends, concurrent with o_tx_active=0; otherwise 0.
REQ-019 Bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, reset to 0 on every bit boundary; no wrap-around beyond terminal value.
REQ-020 i_tx_byte_rdy SHALL be ignored while o_tx_active=1; the latched byte SHALL NOT change mid-frame even if i_tx_byte changes.
REQ-021 Back-to-back: i_tx_byte_rdy=1 in the cycle o_tx_done=1 SHALL be accepted; the next start bit begins the following cycle (one idle-high cycle between frames).
REQ-022 Held request: i_tx_byte_rdy held continuously SHALL send one frame per acceptance (each IDLE entry accepts once).

Reset
REQ-023 i_rst=1 at a rising edge SHALL force state IDLE, o_tx_serial=1, o_tx_active=0, o_tx_done=0, counters and shift register 0, on the next cycle.
REQ-024 Reset mid-frame SHALL abort the frame without an o_tx_done pulse; i_rst has priority over i_tx_byte_rdy.
REQ-025 After reset deassertion, the block SHALL accept a request in the first cycle i_rst=0.

Verification (CLKS_PER_BIT=4)
REQ-026 Single byte: pulse rdy with 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each held 4 cycles (40 cycles), active high 40 cycles, done pulse once at cycle 41.
REQ-027 Back-to-back: rdy with 0x00 then rdy with 0xFF in the done cycle -> two frames separated by exactly one idle-high cycle, two done pulses 41 cycles apart.
REQ-028 Busy ignore: rdy with 0x3C at cycle 10 of a 0x55 frame -> only 0x55 transmitted, one done pulse, line idle afterwards.
REQ-029 Mid-frame reset: assert i_rst during DATA bit 3 -> next cycle line=1, active=0, no done pulse; new 0x81 request then sends correctly.
REQ-030 Held request with i_tx_byte changing 0x01->0x02 after acceptance -> first frame carries 0x01, second carries 0x02.
